// File: rtl/inst_axi_bridge.sv
// Instruction-side AXI4 read bridge: turns one core fetch request into a
// single AR burst and returns two consecutive words with one data_ok pulse.
module inst_axi_bridge #(
  parameter logic [3:0] AXI_ID = 4'd0
) (
  input  logic        clk,
  input  logic        rst,
  // Core fetch port
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  input  logic        inst_cache,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst1_rdata,
  output logic [31:0] inst2_rdata,
  // AXI4 read address channel
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [3:0]  arcache,
  output logic        arvalid,
  input  logic        arready,
  // AXI4 read data channel
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [29:0] addr_q;
  logic        cache_q;
  // Set when the burst carries two beats; clear for the single-beat case at
  // the top word of a 4KB page, so a second beat never crosses the page.
  logic        len_q;
  logic [1:0]  beat_cnt;
  logic [31:0] inst1_q;
  logic [31:0] inst2_q;

  logic        accept;
  logic        beat;
  logic        page_top;

  // Address bits [1:0] are ignored and rresp is deliberately not inspected.
  logic        unused_bits;
  assign unused_bits = ^{inst_addr[1:0], rresp};

  assign accept   = (state == IDLE) && inst_req;
  assign beat     = (state == R) && rvalid;
  assign page_top = (inst_addr[11:2] == 10'h3FF);

  assign arid    = AXI_ID;
  assign araddr  = {addr_q, 2'b00};
  assign arlen   = {7'd0, len_q};
  assign arsize  = 3'b010;
  assign arburst = 2'b01;
  assign arcache = cache_q ? 4'b1111 : 4'b0000;

  assign inst1_rdata = inst1_q;
  assign inst2_rdata = inst2_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and handshake outputs for the one-outstanding-request FSM.
  always_comb begin
    state_next   = state;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    arvalid      = 1'b0;
    rready       = 1'b0;
    case (state)
      IDLE: begin
        inst_addr_ok = inst_req;
        if (inst_req) begin
          state_next = AR;
        end
      end
      AR: begin
        arvalid = 1'b1;
        if (arready) begin
          state_next = R;
        end
      end
      R: begin
        rready = 1'b1;
        if (rvalid && rlast) begin
          state_next = RESP;
        end
      end
      RESP: begin
        inst_data_ok = 1'b1;
        state_next   = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Request latch, beat counter and instruction word capture; the words are
  // only written by beats so they hold between bursts for the fetch stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= 30'd0;
      cache_q  <= 1'b0;
      len_q    <= 1'b0;
      beat_cnt <= 2'd0;
      inst1_q  <= 32'd0;
      inst2_q  <= 32'd0;
    end else begin
      if (accept) begin
        addr_q   <= inst_addr[31:2];
        cache_q  <= inst_cache;
        len_q    <= ~page_top;
        beat_cnt <= 2'd0;
      end
      if (beat) begin
        if (beat_cnt == 2'd0) begin
          inst1_q <= rdata;
          if (rlast || !len_q) begin
            inst2_q <= 32'd0;
          end
        end else if (beat_cnt == 2'd1) begin
          inst2_q <= len_q ? rdata : 32'd0;
        end
        if (beat_cnt != 2'd2) begin
          beat_cnt <= beat_cnt + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_inst_axi_bridge.sv
// Directed self-checking bench for inst_axi_bridge: a table of single-burst
// vectors plus hand-written back-to-back and reset-mid-burst sequences.
module tb_inst_axi_bridge;

  logic        clk;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_cache;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst1_rdata;
  logic [31:0] inst2_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [3:0]  arcache;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] addr;
    logic        cache;
    int          ar_wait;
    int          gap;
    int          nbeats;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [1:0]  resp;
    logic [31:0] exp_araddr;
    logic [7:0]  exp_arlen;
    logic [3:0]  exp_arcache;
    logic [31:0] exp_i1;
    logic [31:0] exp_i2;
    int          exp_lat;
  } vec_t;

  vec_t vecs[6];

  inst_axi_bridge #(.AXI_ID(4'd0)) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_cache   (inst_cache),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst1_rdata  (inst1_rdata),
    .inst2_rdata  (inst2_rdata),
    .arid         (arid),
    .araddr       (araddr),
    .arlen        (arlen),
    .arsize       (arsize),
    .arburst      (arburst),
    .arcache      (arcache),
    .arvalid      (arvalid),
    .arready      (arready),
    .rdata        (rdata),
    .rresp        (rresp),
    .rlast        (rlast),
    .rvalid       (rvalid),
    .rready       (rready)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Run one complete request through the bridge, acting as the AXI slave.
  task automatic applyStimulus(input vec_t v);
    int lat;
    logic [31:0] bd[3];
    bd[0] = v.d0;
    bd[1] = v.d1;
    bd[2] = v.d2;
    @(negedge clk);
    inst_req   = 1'b1;
    inst_addr  = v.addr;
    inst_cache = v.cache;
    #1;
    checkOutput("addr_ok_accept", {31'd0, inst_addr_ok}, 32'd1);
    lat = 0;
    @(negedge clk);
    lat++;
    inst_req = 1'b0;
    arready  = (v.ar_wait == 0);
    #1;
    checkOutput("arvalid", {31'd0, arvalid}, 32'd1);
    checkOutput("araddr", araddr, v.exp_araddr);
    checkOutput("arlen", {24'd0, arlen}, {24'd0, v.exp_arlen});
    checkOutput("arcache", {28'd0, arcache}, {28'd0, v.exp_arcache});
    checkOutput("addr_ok_in_ar", {31'd0, inst_addr_ok}, 32'd0);
    for (int i = 0; i < v.ar_wait; i++) begin
      @(negedge clk);
      lat++;
      arready = (i == v.ar_wait - 1);
      #1;
      checkOutput("arvalid_held", {31'd0, arvalid}, 32'd1);
      checkOutput("araddr_stable", araddr, v.exp_araddr);
    end
    @(negedge clk);
    lat++;
    arready = 1'b0;
    for (int i = 0; i < v.nbeats; i++) begin
      if (i > 0) begin
        for (int g = 0; g < v.gap; g++) begin
          rvalid = 1'b0;
          #1;
          checkOutput("rready_gap", {31'd0, rready}, 32'd1);
          @(negedge clk);
          lat++;
        end
      end
      rvalid = 1'b1;
      rdata  = bd[i];
      rlast  = (i == v.nbeats - 1);
      rresp  = v.resp;
      #1;
      checkOutput("rready_beat", {31'd0, rready}, 32'd1);
      checkOutput("data_ok_early", {31'd0, inst_data_ok}, 32'd0);
      @(negedge clk);
      lat++;
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    rresp  = 2'b00;
    #1;
    checkOutput("data_ok", {31'd0, inst_data_ok}, 32'd1);
    checkOutput("latency", lat, v.exp_lat);
    checkOutput("inst1_rdata", inst1_rdata, v.exp_i1);
    checkOutput("inst2_rdata", inst2_rdata, v.exp_i2);
    checkOutput("rready_resp", {31'd0, rready}, 32'd0);
    @(negedge clk);
    #1;
    checkOutput("data_ok_single_pulse", {31'd0, inst_data_ok}, 32'd0);
    checkOutput("inst1_hold", inst1_rdata, v.exp_i1);
    checkOutput("inst2_hold", inst2_rdata, v.exp_i2);
  endtask

  // Main test sequence.
  initial begin
    rst        = 1'b1;
    inst_req   = 1'b0;
    inst_addr  = 32'd0;
    inst_cache = 1'b0;
    arready    = 1'b0;
    rdata      = 32'd0;
    rresp      = 2'b00;
    rlast      = 1'b0;
    rvalid     = 1'b0;

    //            addr          c  arw gap n  d0            d1            d2            resp   araddr        len   cache  i1            i2            lat
    vecs[0] = '{32'hBFC0_0000, 1'b0, 0, 0, 2, 32'h2408_0001, 32'h2409_0002, 32'h0,        2'b00, 32'hBFC0_0000, 8'd1, 4'h0, 32'h2408_0001, 32'h2409_0002, 4};
    vecs[1] = '{32'h0000_0FFC, 1'b1, 0, 0, 1, 32'hDEAD_BEEF, 32'h0,        32'h0,        2'b00, 32'h0000_0FFC, 8'd0, 4'hF, 32'hDEAD_BEEF, 32'h0,        3};
    vecs[2] = '{32'h0040_0010, 1'b1, 3, 2, 2, 32'h1111_1111, 32'h2222_2222, 32'h0,        2'b00, 32'h0040_0010, 8'd1, 4'hF, 32'h1111_1111, 32'h2222_2222, 9};
    vecs[3] = '{32'h8000_0006, 1'b0, 0, 0, 2, 32'hAAAA_0001, 32'hAAAA_0002, 32'h0,        2'b10, 32'h8000_0004, 8'd1, 4'h0, 32'hAAAA_0001, 32'hAAAA_0002, 4};
    vecs[4] = '{32'h0000_1000, 1'b0, 0, 0, 1, 32'h5555_0001, 32'h0,        32'h0,        2'b00, 32'h0000_1000, 8'd1, 4'h0, 32'h5555_0001, 32'h0,        3};
    vecs[5] = '{32'h0000_2000, 1'b1, 1, 1, 3, 32'h7777_0001, 32'h7777_0002, 32'h7777_0003, 2'b00, 32'h0000_2000, 8'd1, 4'hF, 32'h7777_0001, 32'h7777_0002, 8};

    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
    checkOutput("rst_data_ok", {31'd0, inst_data_ok}, 32'd0);
    checkOutput("rst_arvalid", {31'd0, arvalid}, 32'd0);
    checkOutput("rst_rready", {31'd0, rready}, 32'd0);
    checkOutput("rst_inst1", inst1_rdata, 32'd0);
    checkOutput("rst_inst2", inst2_rdata, 32'd0);
    checkOutput("rst_araddr", araddr, 32'd0);
    checkOutput("rst_arlen", {24'd0, arlen}, 32'd0);
    checkOutput("rst_arcache", {28'd0, arcache}, 32'd0);
    checkOutput("arid", {28'd0, arid}, 32'd0);
    checkOutput("arsize", {29'd0, arsize}, 32'd2);
    checkOutput("arburst", {30'd0, arburst}, 32'd1);
    rst = 1'b0;

    for (int k = 0; k < 6; k++) begin
      $display("[TB] vector %0d addr %h", k, vecs[k].addr);
      applyStimulus(vecs[k]);
    end

    // Back-to-back with inst_req held high across the first burst.
    $display("[TB] back-to-back sequence");
    @(negedge clk);
    inst_req  = 1'b1;
    inst_addr = 32'h0000_3000;
    inst_cache = 1'b0;
    #1;
    checkOutput("b2b_accept1", {31'd0, inst_addr_ok}, 32'd1);
    @(negedge clk);
    arready = 1'b1;
    #1;
    checkOutput("b2b_arvalid1", {31'd0, arvalid}, 32'd1);
    checkOutput("b2b_addr_ok_ar", {31'd0, inst_addr_ok}, 32'd0);
    @(negedge clk);
    arready = 1'b0;
    rvalid  = 1'b1;
    rdata   = 32'h0000_AAAA;
    rlast   = 1'b0;
    @(negedge clk);
    rdata   = 32'h0000_BBBB;
    rlast   = 1'b1;
    @(negedge clk);
    rvalid    = 1'b0;
    rlast     = 1'b0;
    inst_addr = 32'h0000_4000;
    #1;
    checkOutput("b2b_data_ok1", {31'd0, inst_data_ok}, 32'd1);
    checkOutput("b2b_addr_ok_resp", {31'd0, inst_addr_ok}, 32'd0);
    @(negedge clk);
    #1;
    checkOutput("b2b_accept2", {31'd0, inst_addr_ok}, 32'd1);
    checkOutput("b2b_hold_i1_idle", inst1_rdata, 32'h0000_AAAA);
    checkOutput("b2b_hold_i2_idle", inst2_rdata, 32'h0000_BBBB);
    @(negedge clk);
    inst_req = 1'b0;
    arready  = 1'b1;
    #1;
    checkOutput("b2b_araddr2", araddr, 32'h0000_4000);
    checkOutput("b2b_hold_i1_ar", inst1_rdata, 32'h0000_AAAA);
    @(negedge clk);
    arready = 1'b0;
    rvalid  = 1'b1;
    rdata   = 32'h0000_CCCC;
    #1;
    checkOutput("b2b_hold_i2_beat0", inst2_rdata, 32'h0000_BBBB);
    @(negedge clk);
    rdata = 32'h0000_DDDD;
    rlast = 1'b1;
    #1;
    checkOutput("b2b_new_i1", inst1_rdata, 32'h0000_CCCC);
    checkOutput("b2b_hold_i2_beat1", inst2_rdata, 32'h0000_BBBB);
    @(negedge clk);
    rvalid = 1'b0;
    rlast  = 1'b0;
    #1;
    checkOutput("b2b_data_ok2", {31'd0, inst_data_ok}, 32'd1);
    checkOutput("b2b_i1", inst1_rdata, 32'h0000_CCCC);
    checkOutput("b2b_i2", inst2_rdata, 32'h0000_DDDD);
    @(negedge clk);

    // Reset one cycle after the first beat of a burst.
    $display("[TB] reset mid-burst sequence");
    @(negedge clk);
    inst_req   = 1'b1;
    inst_addr  = 32'h0000_5000;
    inst_cache = 1'b1;
    @(negedge clk);
    inst_req = 1'b0;
    arready  = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    rvalid  = 1'b1;
    rdata   = 32'h1234_5678;
    rlast   = 1'b0;
    @(negedge clk);
    rvalid = 1'b0;
    rst    = 1'b1;
    #1;
    checkOutput("rmb_beat_taken", inst1_rdata, 32'h1234_5678);
    @(negedge clk);
    #1;
    checkOutput("rmb_rready", {31'd0, rready}, 32'd0);
    checkOutput("rmb_arvalid", {31'd0, arvalid}, 32'd0);
    checkOutput("rmb_inst1", inst1_rdata, 32'd0);
    checkOutput("rmb_inst2", inst2_rdata, 32'd0);
    checkOutput("rmb_araddr", araddr, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      checkOutput("rmb_no_data_ok", {31'd0, inst_data_ok}, 32'd0);
      checkOutput("rmb_idle_rready", {31'd0, rready}, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
